// File: rtl/fpmu_op_sequencer.sv
// Byte-serial front end for the FP16 multiplier. It gathers two little-endian operands,
// fires one start pulse, waits for done under a watchdog, and then streams out the product bytes.
module fpmu_op_sequencer #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] op_a,
    output logic [15:0] op_b,
    output logic        mul_start,
    input  logic        mul_done,
    input  logic [15:0] mul_result,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        timeout_err,
    output logic [2:0]  state_dbg
);
    // state  | meaning
    // IDLE   | waiting for op_a low byte
    // LD_A1  | waiting for op_a high byte
    // LD_B0  | waiting for op_b low byte
    // LD_B1  | waiting for op_b high byte
    // ISSUE  | one-cycle mul_start
    // WAIT   | waiting for mul_done under watchdog
    // OUT_LO | presenting result[7:0]
    // OUT_HI | presenting result[15:8]
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LD_A1  = 3'd1,
        LD_B0  = 3'd2,
        LD_B1  = 3'd3,
        ISSUE  = 3'd4,
        WAIT   = 3'd5,
        OUT_LO = 3'd6,
        OUT_HI = 3'd7
    } state_t;

    state_t      state, state_nxt;
    logic [7:0]  wait_cnt;
    logic [15:0] result;
    logic        accept;
    logic        wd_hit;

    assign accept = in_valid && in_ready;
    assign wd_hit = (TIMEOUT != 8'd0) && (wait_cnt == TIMEOUT - 8'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = LD_A1;
            LD_A1:   if (accept) state_nxt = LD_B0;
            LD_B0:   if (accept) state_nxt = LD_B1;
            LD_B1:   if (accept) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT: begin
                // done takes priority over a simultaneous watchdog expiry
                if (mul_done)    state_nxt = OUT_LO;
                else if (wd_hit) state_nxt = IDLE;
            end
            OUT_LO:  if (out_ready) state_nxt = OUT_HI;
            OUT_HI:  if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE) || (state == LD_A1) || (state == LD_B0) || (state == LD_B1);
        busy      = (state != IDLE);
        mul_start = (state == ISSUE);
        state_dbg = state;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_a        <= 16'h0000;
            op_b        <= 16'h0000;
            result      <= 16'h0000;
            wait_cnt    <= 8'd0;
            timeout_err <= 1'b0;
        end else begin
            if (accept) begin
                case (state)
                    IDLE:    op_a[7:0]  <= in_data;
                    LD_A1:   op_a[15:8] <= in_data;
                    LD_B0:   op_b[7:0]  <= in_data;
                    LD_B1:   op_b[15:8] <= in_data;
                    default: ;
                endcase
            end
            if (state == IDLE && accept)
                timeout_err <= 1'b0;
            if (state == ISSUE)
                wait_cnt <= 8'd0;
            if (state == WAIT) begin
                if (mul_done)
                    result <= mul_result;
                else if (wd_hit)
                    timeout_err <= 1'b1;
                else
                    wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

    // Output byte is registered from the next state, so it is stable for the whole OUT_* cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= 8'h00;
        end else begin
            out_valid <= (state_nxt == OUT_LO) || (state_nxt == OUT_HI);
            case (state_nxt)
                OUT_LO:  out_data <= (state == WAIT) ? mul_result[7:0] : result[7:0];
                OUT_HI:  out_data <= result[15:8];
                default: out_data <= 8'h00;
            endcase
        end
    end
endmodule

// File: tb/tb_fpmu_op_sequencer.sv
// Directed bench for fpmu_op_sequencer (TIMEOUT=8); inputs are driven and outputs sampled on negedge.
module tb_fpmu_op_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] op_a, op_b;
    logic        mul_start;
    logic        mul_done;
    logic [15:0] mul_result;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        timeout_err;
    logic [2:0]  state_dbg;

    int vectors = 0;
    int errors  = 0;
    int start_cnt = 0;

    fpmu_op_sequencer #(.TIMEOUT(8'd8)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .mul_start(mul_start), .mul_done(mul_done),
        .mul_result(mul_result), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .timeout_err(timeout_err), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mul_start) start_cnt <= start_cnt + 1;

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_data  = b;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        vectors++;
        if (t >= 50) begin
            errors++;
            $display("FAIL send_byte: in_ready never rose for byte %02h", b);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic feed(input logic [15:0] a, input logic [15:0] b, input int gap);
        send_byte(a[7:0], gap);
        send_byte(a[15:8], gap);
        send_byte(b[7:0], gap);
        send_byte(b[15:8], gap);
    endtask

    // Called at the negedge of the ISSUE cycle; models a multiplier answering after 'delay' cycles
    task automatic run_mul(input logic [15:0] a, input logic [15:0] b, input logic [15:0] res,
                           input int delay, input bit issue_done);
        vectors++;
        if (mul_start !== 1'b1 || state_dbg !== 3'd4) begin
            errors++;
            $display("FAIL issue: mul_start=%b state=%0d, want 1/4", mul_start, state_dbg);
        end
        vectors++;
        if (op_a !== a || op_b !== b) begin
            errors++;
            $display("FAIL operands: op_a=%04h op_b=%04h, want %04h %04h", op_a, op_b, a, b);
        end
        if (issue_done) mul_done = 1'b1;
        for (int d = 1; d <= delay; d++) begin
            @(negedge clk);
            mul_done = 1'b0;
            vectors++;
            if (state_dbg !== 3'd5 || mul_start !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL wait d=%0d: state=%0d start=%b ov=%b, want 5/0/0", d, state_dbg, mul_start, out_valid);
            end
            if (d == delay) begin
                mul_done   = 1'b1;
                mul_result = res;
            end
        end
        @(negedge clk);
        mul_done   = 1'b0;
        mul_result = 16'h0000;
    endtask

    task automatic collect(input logic [15:0] res, input int stall);
        int t;
        logic [7:0] exp;
        for (int i = 0; i < 2; i++) begin
            t = 0;
            while (!out_valid && t < 50) begin
                @(negedge clk);
                t++;
            end
            exp = (i == 0) ? res[7:0] : res[15:8];
            vectors++;
            if (t >= 50 || out_data !== exp || state_dbg !== 3'(6 + i)) begin
                errors++;
                $display("FAIL out byte %0d: data=%02h state=%0d waited=%0d, want %02h", i, out_data, state_dbg, t, exp);
            end
            for (int s = 0; s < stall; s++) begin
                out_ready = 1'b0;
                @(negedge clk);
                vectors++;
                if (out_valid !== 1'b1 || out_data !== exp) begin
                    errors++;
                    $display("FAIL out stall %0d/%0d: ov=%b data=%02h, want 1/%02h", i, s, out_valid, out_data, exp);
                end
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
        vectors++;
        if (busy !== 1'b0 || state_dbg !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL op end: busy=%b state=%0d ov=%b ir=%b, want 0/0/0/1", busy, state_dbg, out_valid, in_ready);
        end
    endtask

    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] res,
                         input int delay, input int gap, input int stall);
        int s0;
        s0 = start_cnt;
        feed(a, b, gap);
        run_mul(a, b, res, delay, 1'b0);
        collect(res, stall);
        vectors++;
        if (start_cnt - s0 != 1) begin
            errors++;
            $display("FAIL start count: got %0d pulses, want 1", start_cnt - s0);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; in_data = 8'h00; in_valid = 1'b0; mul_done = 1'b0;
        mul_result = 16'h0000; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (state_dbg !== 3'd0 || op_a !== 16'h0 || op_b !== 16'h0 || in_ready !== 1'b1 ||
            mul_start !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'h00 || busy !== 1'b0 ||
            timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL reset values: state=%0d a=%04h b=%04h ir=%b st=%b ov=%b od=%02h busy=%b err=%b",
                     state_dbg, op_a, op_b, in_ready, mul_start, out_valid, out_data, busy, timeout_err);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_nominal;
        do_op(16'h3E00, 16'h4000, 16'h4200, 3, 0, 0);
    endtask

    task automatic test_stalls;
        do_op(16'h3E00, 16'h4000, 16'h4200, 3, 1, 5);
    endtask

    task automatic test_back_to_back;
        do_op(16'h1234, 16'h5678, 16'hA55A, 2, 0, 0);
        do_op(16'h0001, 16'h8000, 16'h7F81, 1, 0, 0);
    endtask

    task automatic test_watchdog;
        feed(16'h3E00, 16'h4000, 0);
        vectors++;
        if (mul_start !== 1'b1) begin
            errors++;
            $display("FAIL wd issue: mul_start=%b, want 1", mul_start);
        end
        for (int d = 1; d <= 8; d++) begin
            @(negedge clk);
            vectors++;
            if (state_dbg !== 3'd5 || out_valid !== 1'b0 || timeout_err !== 1'b0) begin
                errors++;
                $display("FAIL wd wait d=%0d: state=%0d ov=%b err=%b, want 5/0/0", d, state_dbg, out_valid, timeout_err);
            end
        end
        @(negedge clk);
        vectors++;
        if (state_dbg !== 3'd0 || timeout_err !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL wd abort: state=%0d err=%b ov=%b, want 0/1/0", state_dbg, timeout_err, out_valid);
        end
        send_byte(8'h00, 0);
        vectors++;
        if (timeout_err !== 1'b0 || state_dbg !== 3'd1) begin
            errors++;
            $display("FAIL wd clear: err=%b state=%0d, want 0/1", timeout_err, state_dbg);
        end
        send_byte(8'h3E, 0);
        send_byte(8'h00, 0);
        send_byte(8'h40, 0);
        run_mul(16'h3E00, 16'h4000, 16'h4200, 3, 1'b0);
        collect(16'h4200, 0);
    endtask

    task automatic test_timeout_race;
        do_op(16'h3E00, 16'h4000, 16'h4200, 8, 0, 0);
        vectors++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL race: timeout_err=%b, want 0", timeout_err);
        end
    endtask

    task automatic test_spurious;
        int s0;
        s0 = start_cnt;
        mul_done = 1'b1;
        @(negedge clk);
        mul_done = 1'b0;
        vectors++;
        if (state_dbg !== 3'd0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL spurious idle: state=%0d busy=%b ov=%b, want 0/0/0", state_dbg, busy, out_valid);
        end
        send_byte(8'h00, 0);
        send_byte(8'h3E, 0);
        mul_done = 1'b1;
        @(negedge clk);
        mul_done = 1'b0;
        vectors++;
        if (state_dbg !== 3'd2 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL spurious ld_b0: state=%0d ov=%b, want 2/0", state_dbg, out_valid);
        end
        send_byte(8'h00, 0);
        send_byte(8'h40, 0);
        run_mul(16'h3E00, 16'h4000, 16'h4200, 3, 1'b1);
        collect(16'h4200, 0);
        vectors++;
        if (start_cnt - s0 != 1) begin
            errors++;
            $display("FAIL spurious starts: got %0d, want 1", start_cnt - s0);
        end
    endtask

    task automatic test_reset_mid_wait;
        feed(16'h3E00, 16'h4000, 0);
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (state_dbg !== 3'd5) begin
            errors++;
            $display("FAIL pre-reset state=%0d, want 5", state_dbg);
        end
        #2 reset = 1'b1;
        #1;
        vectors++;
        if (state_dbg !== 3'd0 || op_a !== 16'h0 || op_b !== 16'h0 || in_ready !== 1'b1 ||
            mul_start !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL async reset: state=%0d a=%04h b=%04h ir=%b st=%b ov=%b busy=%b",
                     state_dbg, op_a, op_b, in_ready, mul_start, out_valid, busy);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        do_op(16'h3C00, 16'hC000, 16'hC000, 3, 0, 0);
    endtask

    initial begin
        test_reset;
        test_nominal;
        test_stalls;
        test_back_to_back;
        test_watchdog;
        test_timeout_race;
        test_spurious;
        test_reset_mid_wait;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/fpmu_op_sequencer.md
Name: fpmu_op_sequencer

Overview:
- Byte-serial front-end controller for the FP16 multiplier core.
- Assembles two 16-bit operands from the 8-bit input bus, issues a single start pulse to the multiplier and waits for its done strobe under a watchdog.
- Streams the 16-bit product back out as two bytes.
- Sits between the top-level pins and the multiplier datapath; a debug state code drives the bidirectional pins.

Parameters:
- TIMEOUT, 8'd255: maximum WAIT cycles before abort. 0 disables the watchdog.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- in_data  input  8  operand byte
- in_valid  input  1  in_data valid
- in_ready  output  1  sequencer accepts a byte this cycle
- op_a  output  16  operand A to the multiplier
- op_b  output  16  operand B to the multiplier
- mul_start  output  1  one-cycle start pulse to the multiplier
- mul_done  input  1  multiplier result valid (single-cycle strobe)
- mul_result  input  16  multiplier product
- out_data  output  8  result byte
- out_valid  output  1  out_data valid
- out_ready  input  1  consumer takes the byte
- busy  output  1  high in every state except IDLE
- timeout_err  output  1  sticky watchdog abort flag
- state_dbg  output  3  current state encoding

Behaviour:
- Clock and reset: single clock domain. Reset is asynchronous and active-high; all registers clear immediately.
- Reset values: state=IDLE, op_a=op_b=0, result=0, wait counter=0, in_ready=1, mul_start=0, out_valid=0, out_data=0, busy=0, timeout_err=0.
- State encodings (state_dbg): IDLE=0, LD_A1=1, LD_B0=2, LD_B1=3, ISSUE=4, WAIT=5, OUT_LO=6, OUT_HI=7.
- Input handshake: a byte transfers on a clk edge with in_valid && in_ready. in_ready=1 only in IDLE, LD_A1, LD_B0, LD_B1.
- Byte order is little-endian.
  - IDLE accept → op_a[7:0], next LD_A1. The same edge clears timeout_err.
  - LD_A1 accept → op_a[15:8], next LD_B0.
  - LD_B0 accept → op_b[7:0], next LD_B1.
  - LD_B1 accept → op_b[15:8], next ISSUE.
- Without a transfer the state holds; there is no inter-byte timeout.
- ISSUE: mul_start=1 for exactly this one cycle. Wait counter cleared. Next state is WAIT unconditionally. mul_done in the ISSUE cycle is ignored.
- op_a and op_b are stable from ISSUE until the next IDLE accept.
- WAIT:
  - mul_done=1 → capture mul_result into the result register, go to OUT_LO.
  - Otherwise the counter increments.
  - If TIMEOUT!=0 and the counter equals TIMEOUT-1 with no mul_done → timeout_err=1, return to IDLE, no output bytes.
  - mul_done on the same cycle as the timeout condition: done wins, no error.
- mul_done outside WAIT is ignored, and no state changes on it.
- OUT_LO: out_valid=1, out_data=result[7:0]. On out_ready go to OUT_HI.
- OUT_HI: out_valid=1, out_data=result[15:8]. On out_ready go to IDLE.
- out_data and out_valid are registered. out_data is held stable while out_valid && !out_ready. out_valid=0 in all other states.
- Latency:
  - Last input byte accepted at edge N → mul_start high in cycle N+1.
  - mul_done sampled at edge M → out_valid high from cycle M+1.
- Back-to-back operations: a new byte can be accepted in the cycle after the OUT_HI transfer.
- Reset mid-operation: aborts immediately, discards partial operands and any pending output, and issues no further mul_start.

Test Plan:
- Nominal: feed 00,3E,00,40 (A=0x3E00, B=0x4000). The model returns 0x4200 with mul_done 3 cycles after mul_start. Required: exactly one mul_start; op_a=0x3E00, op_b=0x4000; bytes 00 then 42 on the output; busy returns to 0.
- Handshake stalls: in_valid toggles every other cycle and out_ready is held low 5 cycles per byte. Required: no byte lost or duplicated; out_data held constant while stalled; same 00,42 result.
- Watchdog: TIMEOUT=8 and the model never asserts mul_done. Required: timeout_err=1 and state=IDLE 8 cycles after the ISSUE cycle, with no out_valid. The next IDLE byte accept clears timeout_err.
- Timeout race: TIMEOUT=8 and mul_done arrives on the 8th WAIT cycle. Required: no error; result output normally.
- Spurious strobes: mul_done pulsed in IDLE, in LD_B0 and in the ISSUE cycle. Required: no state change and no output.
- Reset mid-WAIT: assert reset asynchronously between clk edges. Required: all outputs reach reset values before the next edge. A following 4-byte sequence (A=0x3C00, B=0xC000, model result 0xC000) produces output 00,C0.
